// File: rtl/snitch_icache_refill_handler.sv
// Icache miss/refill handler: merges misses in a pending table, assembles refill beats into lines,
// arbitrates hit/refill responses. Define ICACHE_HANDLER_ORDER_EN to stall lookups whose id has a miss in flight.
module snitch_icache_refill_handler #(
   parameter int unsigned FETCH_AW      = 32,
   parameter int unsigned LINE_WIDTH    = 128,
   parameter int unsigned BEAT_WIDTH    = 32,
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned PENDING_COUNT = 4,
   parameter int unsigned WAY_COUNT     = 4,
   parameter int unsigned SET_COUNT     = 64,
   localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH,
   localparam int unsigned PIW   = $clog2(PENDING_COUNT),
   localparam int unsigned WAW   = $clog2(WAY_COUNT),
   localparam int unsigned SAW   = $clog2(SET_COUNT),
   localparam int unsigned LA    = $clog2(LINE_WIDTH / 8),
   localparam int unsigned TAG_W = FETCH_AW - LA - SAW
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [FETCH_AW-1:0]   in_req_addr_i,
   input  logic [ID_WIDTH-1:0]   in_req_id_i,
   input  logic [WAW-1:0]        in_req_way_i,
   input  logic                  in_req_hit_i,
   input  logic [LINE_WIDTH-1:0] in_req_data_i,
   input  logic                  in_req_valid_i,
   output logic                  in_req_ready_o,
   output logic [LINE_WIDTH-1:0] in_rsp_data_o,
   output logic                  in_rsp_error_o,
   output logic [ID_WIDTH-1:0]   in_rsp_id_o,
   output logic                  in_rsp_valid_o,
   input  logic                  in_rsp_ready_i,
   output logic [SAW-1:0]        write_addr_o,
   output logic [WAW-1:0]        write_way_o,
   output logic [LINE_WIDTH-1:0] write_data_o,
   output logic [TAG_W-1:0]      write_tag_o,
   output logic                  write_error_o,
   output logic                  write_valid_o,
   input  logic                  write_ready_i,
   output logic [FETCH_AW-1:0]   out_req_addr_o,
   output logic [PIW-1:0]        out_req_id_o,
   output logic                  out_req_valid_o,
   input  logic                  out_req_ready_i,
   input  logic [BEAT_WIDTH-1:0] out_rsp_data_i,
   input  logic                  out_rsp_error_i,
   input  logic [PIW-1:0]        out_rsp_id_i,
   input  logic                  out_rsp_last_i,
   input  logic                  out_rsp_valid_i,
   output logic                  out_rsp_ready_o
);

   localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [PENDING_COUNT-1:0] valid_reg;
   logic [FETCH_AW-1:0]      addr_reg [PENDING_COUNT];
   logic [ID_WIDTH-1:0]      mask_reg [PENDING_COUNT];

   logic [BEAT_WIDTH-1:0]    beat_reg [BEATS];
   logic [LINE_WIDTH-1:0]    line_buf;
   logic [CW-1:0]            cnt_reg;
   logic                     line_full_reg;
   logic                     line_err_reg;
   logic [PIW-1:0]           line_id_reg;
   logic                     write_served_reg;
   logic                     rsp_served_reg;
   logic                     rr_line_reg;
   logic                     lock_valid_reg;
   logic                     lock_line_reg;
   logic [WAW-1:0]           victim_reg;

   logic                     blocked;
   logic                     hit_req;
   logic                     is_miss;
   logic                     merge;
   logic                     alloc_req;
   logic                     alloc;
   logic [PENDING_COUNT-1:0] match_vec;
   logic [PENDING_COUNT-1:0] free_vec;
   logic [PIW-1:0]           alloc_idx;
   logic [ID_WIDTH-1:0]      line_mask;
   logic                     line_req;
   logic                     grant_line;
   logic                     rsp_fire;
   logic                     line_rsp_fire;
   logic                     write_fire;
   logic                     line_done;
   logic                     beat_fire;
   logic                     beat_end;
   logic                     unused_way;

   assign unused_way = ^in_req_way_i;

   // An entry whose response already went out only waits for its write; new misses must not merge into it.
   for (genvar gi = 0; gi < PENDING_COUNT; gi++) begin : g_entry
      assign match_vec[gi] = valid_reg[gi] && (addr_reg[gi] == in_req_addr_i)
                          && !(line_full_reg && rsp_served_reg && (line_id_reg == PIW'(gi)));
      assign free_vec[gi]  = !valid_reg[gi];
   end

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
      assign line_buf[gi*BEAT_WIDTH +: BEAT_WIDTH] = beat_reg[gi];
   end

   always_comb begin
      alloc_idx = '0;
      for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
         if (free_vec[i]) alloc_idx = PIW'(i);
      end
   end

   always_comb begin
      hit_req   = in_req_valid_i && in_req_hit_i && !blocked;
      is_miss   = in_req_valid_i && !in_req_hit_i && !blocked;
      merge     = is_miss && (|match_vec);
      alloc_req = is_miss && !(|match_vec) && (|free_vec);
      alloc     = alloc_req && out_req_ready_i;
   end

   assign out_req_valid_o = alloc_req;
   assign out_req_addr_o  = in_req_addr_i;
   assign out_req_id_o    = alloc_idx;

   // A miss merging into the line being popped this cycle is served by that same response.
   always_comb begin
      line_mask = mask_reg[line_id_reg];
      if (merge && match_vec[line_id_reg]) line_mask = line_mask | in_req_id_i;
   end

   assign line_req = line_full_reg && !rsp_served_reg && (|line_mask);

   always_comb begin
      grant_line = line_req;
      if (hit_req && line_req) grant_line = lock_valid_reg ? lock_line_reg : rr_line_reg;
   end

   assign in_rsp_valid_o = hit_req || line_req;
   assign in_rsp_data_o  = grant_line ? line_buf : in_req_data_i;
   assign in_rsp_error_o = grant_line && line_err_reg;
   assign in_rsp_id_o    = grant_line ? line_mask : in_req_id_i;
   assign rsp_fire       = in_rsp_valid_o && in_rsp_ready_i;
   assign line_rsp_fire  = rsp_fire && grant_line;
   assign in_req_ready_o = (hit_req && !grant_line && in_rsp_ready_i) || merge || alloc;

   assign write_valid_o = line_full_reg && !write_served_reg;
   assign write_addr_o  = addr_reg[line_id_reg][LA +: SAW];
   assign write_tag_o   = addr_reg[line_id_reg][FETCH_AW-1 : LA+SAW];
   assign write_data_o  = line_buf;
   assign write_error_o = line_err_reg;
   assign write_way_o   = victim_reg;
   assign write_fire    = write_valid_o && write_ready_i;

   assign line_done = line_full_reg && (write_served_reg || write_fire)
                   && (rsp_served_reg || line_rsp_fire || !(|line_mask));

   assign out_rsp_ready_o = !line_full_reg;
   assign beat_fire       = out_rsp_valid_i && !line_full_reg;
   assign beat_end        = out_rsp_last_i || (cnt_reg == CW'(BEATS - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_reg <= '0;
         for (int i = 0; i < PENDING_COUNT; i++) begin
            addr_reg[i] <= '0;
            mask_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < PENDING_COUNT; i++) begin
            if (line_done && (line_id_reg == PIW'(i))) begin
               valid_reg[i] <= 1'b0;
               mask_reg[i]  <= '0;
            end else if (alloc && (alloc_idx == PIW'(i))) begin
               valid_reg[i] <= 1'b1;
               addr_reg[i]  <= in_req_addr_i;
               mask_reg[i]  <= in_req_id_i;
            end else if (merge && match_vec[i]) begin
               mask_reg[i]  <= mask_reg[i] | in_req_id_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < BEATS; i++) beat_reg[i] <= '0;
      end else if (beat_fire) begin
         beat_reg[cnt_reg] <= out_rsp_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_reg          <= '0;
         line_full_reg    <= 1'b0;
         line_err_reg     <= 1'b0;
         line_id_reg      <= '0;
         write_served_reg <= 1'b0;
         rsp_served_reg   <= 1'b0;
         rr_line_reg      <= 1'b0;
         lock_valid_reg   <= 1'b0;
         lock_line_reg    <= 1'b0;
         victim_reg       <= '0;
      end else begin
         if (beat_fire) begin
            line_id_reg  <= out_rsp_id_i;
            // A short refill (last before the final beat) is always reported as an error.
            line_err_reg <= ((cnt_reg == '0) ? 1'b0 : line_err_reg) | out_rsp_error_i
                          | (out_rsp_last_i && (cnt_reg != CW'(BEATS - 1)));
            if (beat_end) begin
               cnt_reg       <= '0;
               line_full_reg <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
         if (line_done) begin
            line_full_reg    <= 1'b0;
            write_served_reg <= 1'b0;
            rsp_served_reg   <= 1'b0;
            victim_reg       <= (victim_reg == WAW'(WAY_COUNT - 1)) ? '0 : victim_reg + 1'b1;
         end else begin
            if (write_fire)    write_served_reg <= 1'b1;
            if (line_rsp_fire) rsp_served_reg   <= 1'b1;
         end
         if (rsp_fire) begin
            rr_line_reg    <= !rr_line_reg;
            lock_valid_reg <= 1'b0;
         end else if (hit_req && line_req) begin
            lock_valid_reg <= 1'b1;
            lock_line_reg  <= grant_line;
         end
      end
   end

`ifdef ICACHE_HANDLER_ORDER_EN
   logic [ID_WIDTH-1:0] in_flight_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         in_flight_reg <= '0;
      end else begin
         in_flight_reg <= (in_flight_reg | ((merge || alloc) ? in_req_id_i : '0))
                        & ~(rsp_fire ? in_rsp_id_o : '0);
      end
   end

   assign blocked = |(in_flight_reg & in_req_id_i);
`else
   assign blocked = 1'b0;
`endif

endmodule

// File: tb/tb_snitch_icache_refill_handler.sv
// Directed self-checking bench for snitch_icache_refill_handler (32-bit lines, 8-bit beats).
module tb_snitch_icache_refill_handler;
   localparam int unsigned FETCH_AW      = 32;
   localparam int unsigned LINE_WIDTH    = 32;
   localparam int unsigned BEAT_WIDTH    = 8;
   localparam int unsigned ID_WIDTH      = 4;
   localparam int unsigned PENDING_COUNT = 4;
   localparam int unsigned WAY_COUNT     = 4;
   localparam int unsigned SET_COUNT     = 64;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic [31:0]           in_req_addr_i;
   logic [3:0]            in_req_id_i;
   logic [1:0]            in_req_way_i;
   logic                  in_req_hit_i;
   logic [31:0]           in_req_data_i;
   logic                  in_req_valid_i;
   logic                  in_req_ready_o;
   logic [31:0]           in_rsp_data_o;
   logic                  in_rsp_error_o;
   logic [3:0]            in_rsp_id_o;
   logic                  in_rsp_valid_o;
   logic                  in_rsp_ready_i;
   logic [5:0]            write_addr_o;
   logic [1:0]            write_way_o;
   logic [31:0]           write_data_o;
   logic [23:0]           write_tag_o;
   logic                  write_error_o;
   logic                  write_valid_o;
   logic                  write_ready_i;
   logic [31:0]           out_req_addr_o;
   logic [1:0]            out_req_id_o;
   logic                  out_req_valid_o;
   logic                  out_req_ready_i;
   logic [7:0]            out_rsp_data_i;
   logic                  out_rsp_error_i;
   logic [1:0]            out_rsp_id_i;
   logic                  out_rsp_last_i;
   logic                  out_rsp_valid_i;
   logic                  out_rsp_ready_o;

   int checks = 0;
   int errors = 0;

   snitch_icache_refill_handler #(
      .FETCH_AW(FETCH_AW), .LINE_WIDTH(LINE_WIDTH), .BEAT_WIDTH(BEAT_WIDTH), .ID_WIDTH(ID_WIDTH),
      .PENDING_COUNT(PENDING_COUNT), .WAY_COUNT(WAY_COUNT), .SET_COUNT(SET_COUNT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_req_addr_i(in_req_addr_i), .in_req_id_i(in_req_id_i), .in_req_way_i(in_req_way_i),
      .in_req_hit_i(in_req_hit_i), .in_req_data_i(in_req_data_i), .in_req_valid_i(in_req_valid_i),
      .in_req_ready_o(in_req_ready_o),
      .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o), .in_rsp_id_o(in_rsp_id_o),
      .in_rsp_valid_o(in_rsp_valid_o), .in_rsp_ready_i(in_rsp_ready_i),
      .write_addr_o(write_addr_o), .write_way_o(write_way_o), .write_data_o(write_data_o),
      .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
      .write_ready_i(write_ready_i),
      .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o), .out_req_valid_o(out_req_valid_o),
      .out_req_ready_i(out_req_ready_i),
      .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i), .out_rsp_id_i(out_rsp_id_i),
      .out_rsp_last_i(out_rsp_last_i), .out_rsp_valid_i(out_rsp_valid_i), .out_rsp_ready_o(out_rsp_ready_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic lookup(input logic [31:0] addr, input logic [3:0] id, input logic hit, input logic [31:0] data);
      in_req_valid_i = 1'b1;
      in_req_addr_i  = addr;
      in_req_id_i    = id;
      in_req_hit_i   = hit;
      in_req_data_i  = data;
   endtask

   task automatic idle();
      in_req_valid_i = 1'b0;
      in_req_hit_i   = 1'b0;
   endtask

   task automatic beat(input logic [7:0] d, input logic last, input logic [1:0] pid);
      out_rsp_valid_i = 1'b1;
      out_rsp_data_i  = d;
      out_rsp_last_i  = last;
      out_rsp_id_i    = pid;
      out_rsp_error_i = 1'b0;
      #1;
      chk("beat_ready", out_rsp_ready_o, 1'b1);
      tick();
      out_rsp_valid_i = 1'b0;
      out_rsp_last_i  = 1'b0;
   endtask

   task automatic full_line(input logic [31:0] d, input logic [1:0] pid);
      beat(d[7:0], 1'b0, pid);
      beat(d[15:8], 1'b0, pid);
      beat(d[23:16], 1'b0, pid);
      beat(d[31:24], 1'b1, pid);
   endtask

   initial begin
      rst_ni = 1'b0;
      in_req_addr_i = '0; in_req_id_i = '0; in_req_way_i = '0; in_req_hit_i = 1'b0;
      in_req_data_i = '0; in_req_valid_i = 1'b0;
      in_rsp_ready_i = 1'b1; write_ready_i = 1'b1; out_req_ready_i = 1'b1;
      out_rsp_data_i = '0; out_rsp_error_i = 1'b0; out_rsp_id_i = '0;
      out_rsp_last_i = 1'b0; out_rsp_valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      chk("rst_in_rsp_valid", in_rsp_valid_o, 1'b0);
      chk("rst_write_valid", write_valid_o, 1'b0);
      chk("rst_out_req_valid", out_req_valid_o, 1'b0);
      chk("rst_out_rsp_ready", out_rsp_ready_o, 1'b1);
      tick();

      // Hit served combinationally
      lookup(32'h0000_0500, 4'b0010, 1'b1, 32'h1234_5678);
      #1;
      chk("hit_valid", in_rsp_valid_o, 1'b1);
      chk("hit_id", in_rsp_id_o, 4'b0010);
      chk("hit_data", in_rsp_data_o, 32'h1234_5678);
      chk("hit_err", in_rsp_error_o, 1'b0);
      chk("hit_ready", in_req_ready_o, 1'b1);
      tick();

      // Two misses to the same line merge into one refill
      lookup(32'h0000_1000, 4'b0001, 1'b0, 32'h0);
      #1;
      chk("miss1_out_valid", out_req_valid_o, 1'b1);
      chk("miss1_out_id", out_req_id_o, 2'd0);
      chk("miss1_out_addr", out_req_addr_o, 32'h0000_1000);
      chk("miss1_ready", in_req_ready_o, 1'b1);
      tick();
      lookup(32'h0000_1000, 4'b0100, 1'b0, 32'h0);
      #1;
      chk("miss2_out_valid", out_req_valid_o, 1'b0);
      chk("miss2_ready", in_req_ready_o, 1'b1);
      tick();
      idle();
      full_line(32'hDDCC_BBAA, 2'd0);
      #1;
      chk("line1_wvalid", write_valid_o, 1'b1);
      chk("line1_wdata", write_data_o, 32'hDDCC_BBAA);
      chk("line1_waddr", write_addr_o, 6'd0);
      chk("line1_wtag", write_tag_o, 24'h000010);
      chk("line1_wway", write_way_o, 2'd0);
      chk("line1_werr", write_error_o, 1'b0);
      chk("line1_rsp_valid", in_rsp_valid_o, 1'b1);
      chk("line1_rsp_id", in_rsp_id_o, 4'b0101);
      chk("line1_rsp_data", in_rsp_data_o, 32'hDDCC_BBAA);
      chk("line1_full_stall", out_rsp_ready_o, 1'b0);
      tick();
      chk("line1_done_wvalid", write_valid_o, 1'b0);
      chk("line1_done_rvalid", in_rsp_valid_o, 1'b0);
      chk("line1_done_ready", out_rsp_ready_o, 1'b1);

      // Fill the pending table with four distinct misses
      lookup(32'h0000_2000, 4'b0001, 1'b0, 32'h0); #1; chk("fill0_id", out_req_id_o, 2'd0); tick();
      lookup(32'h0000_2010, 4'b0010, 1'b0, 32'h0); #1; chk("fill1_id", out_req_id_o, 2'd1); tick();
      lookup(32'h0000_2020, 4'b0100, 1'b0, 32'h0); #1; chk("fill2_id", out_req_id_o, 2'd2); tick();
      lookup(32'h0000_2030, 4'b1000, 1'b0, 32'h0); #1; chk("fill3_id", out_req_id_o, 2'd3); tick();
      lookup(32'h0000_2040, 4'b0001, 1'b0, 32'h0);
      #1;
      chk("full_ready", in_req_ready_o, 1'b0);
      chk("full_out_valid", out_req_valid_o, 1'b0);
      full_line(32'h0403_0201, 2'd0);
      #1;
      chk("free0_rsp_id", in_rsp_id_o, 4'b0001);
      chk("free0_wway", write_way_o, 2'd1);
      chk("free0_wtag", write_tag_o, 24'h000020);
      chk("free0_held_ready", in_req_ready_o, 1'b0);
      tick();
      chk("realloc_valid", out_req_valid_o, 1'b1);
      chk("realloc_id", out_req_id_o, 2'd0);
      chk("realloc_ready", in_req_ready_o, 1'b1);
      tick();
      idle();
      full_line(32'h0807_0605, 2'd0);
      #1;
      chk("e0b_rsp_id", in_rsp_id_o, 4'b0001);
      chk("e0b_wway", write_way_o, 2'd2);
      tick();

      // Arbitration: hit and completed line compete while in_rsp_ready toggles
      in_rsp_ready_i = 1'b0;
      full_line(32'h4433_2211, 2'd1);
      lookup(32'h0000_0600, 4'b0001, 1'b1, 32'hCAFE_F00D);
      #1;
      chk("arbA_id", in_rsp_id_o, 4'b0001);
      chk("arbA_data", in_rsp_data_o, 32'hCAFE_F00D);
      chk("arbA_ready", in_req_ready_o, 1'b0);
      chk("arbA_wvalid", write_valid_o, 1'b1);
      chk("arbA_wway", write_way_o, 2'd3);
      tick();
      in_rsp_ready_i = 1'b1;
      #1;
      chk("arbB_id", in_rsp_id_o, 4'b0001);
      chk("arbB_ready", in_req_ready_o, 1'b1);
      tick();
      in_rsp_ready_i = 1'b0;
      lookup(32'h0000_0600, 4'b0001, 1'b1, 32'hBEEF_0001);
      #1;
      chk("arbC_id", in_rsp_id_o, 4'b0010);
      chk("arbC_data", in_rsp_data_o, 32'h4433_2211);
      chk("arbC_ready", in_req_ready_o, 1'b0);
      chk("arbC_wvalid", write_valid_o, 1'b0);
      tick();
      in_rsp_ready_i = 1'b1;
      #1;
      chk("arbD_id", in_rsp_id_o, 4'b0010);
      chk("arbD_valid", in_rsp_valid_o, 1'b1);
      tick();
      chk("arbE_id", in_rsp_id_o, 4'b0001);
      chk("arbE_data", in_rsp_data_o, 32'hBEEF_0001);
      chk("arbE_ready", in_req_ready_o, 1'b1);
      tick();
      idle();

      // Write array stalls two cycles after the response is accepted
      out_rsp_valid_i = 1'b0;
      beat(8'h55, 1'b0, 2'd2);
      beat(8'h66, 1'b0, 2'd2);
      beat(8'h77, 1'b0, 2'd2);
      write_ready_i = 1'b0;
      beat(8'h88, 1'b1, 2'd2);
      #1;
      chk("wrA_wvalid", write_valid_o, 1'b1);
      chk("wrA_wdata", write_data_o, 32'h8877_6655);
      chk("wrA_waddr", write_addr_o, 6'd8);
      chk("wrA_wway", write_way_o, 2'd0);
      chk("wrA_rvalid", in_rsp_valid_o, 1'b1);
      chk("wrA_rid", in_rsp_id_o, 4'b0100);
      chk("wrA_stall", out_rsp_ready_o, 1'b0);
      tick();
      chk("wrB_rvalid", in_rsp_valid_o, 1'b0);
      chk("wrB_wvalid", write_valid_o, 1'b1);
      chk("wrB_stall", out_rsp_ready_o, 1'b0);
      tick();
      write_ready_i = 1'b1;
      #1;
      chk("wrC_wvalid", write_valid_o, 1'b1);
      chk("wrC_rvalid", in_rsp_valid_o, 1'b0);
      tick();
      chk("wrD_wvalid", write_valid_o, 1'b0);
      chk("wrD_ready", out_rsp_ready_o, 1'b1);

      // Early last beat forces an error
      beat(8'h9A, 1'b0, 2'd3);
      beat(8'hBC, 1'b1, 2'd3);
      #1;
      chk("early_wvalid", write_valid_o, 1'b1);
      chk("early_wdata_lo", write_data_o[15:0], 16'hBC9A);
      chk("early_werr", write_error_o, 1'b1);
      chk("early_rerr", in_rsp_error_o, 1'b1);
      chk("early_rid", in_rsp_id_o, 4'b1000);
      chk("early_wway", write_way_o, 2'd1);
      tick();
      chk("early_done_ready", out_rsp_ready_o, 1'b1);

      // Hit from a requester with an outstanding miss
      lookup(32'h0000_3000, 4'b0001, 1'b0, 32'h0);
      #1;
      chk("ord_miss_id", out_req_id_o, 2'd0);
      tick();
      lookup(32'h0000_0700, 4'b0001, 1'b1, 32'h0BAD_F00D);
      #1;
`ifdef ICACHE_HANDLER_ORDER_EN
      chk("ord_hit_ready", in_req_ready_o, 1'b0);
      chk("ord_hit_valid", in_rsp_valid_o, 1'b0);
`else
      chk("ord_hit_ready", in_req_ready_o, 1'b1);
      chk("ord_hit_valid", in_rsp_valid_o, 1'b1);
`endif
      tick();
      idle();
      full_line(32'hA1B2_C3D4, 2'd0);
      #1;
      chk("ord_line_id", in_rsp_id_o, 4'b0001);
      chk("ord_line_data", in_rsp_data_o, 32'hA1B2_C3D4);
      chk("ord_line_wtag", write_tag_o, 24'h000030);
      chk("ord_line_wway", write_way_o, 2'd2);
      tick();
      lookup(32'h0000_0700, 4'b0001, 1'b1, 32'h0BAD_F00D);
      #1;
      chk("ord_hit2_ready", in_req_ready_o, 1'b1);
      chk("ord_hit2_data", in_rsp_data_o, 32'h0BAD_F00D);
      tick();
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
